// File: rtl/im_loader_if.sv
// Load-stream and instruction-memory bus for im_loader.
//
// Handshake: in_data and in_valid come from the stream source. in_ready comes
// from the loader. A byte moves on a rising clk edge only when in_valid and
// in_ready are both high. A source holding in_valid high must keep in_data
// stable until that edge. Deasserting in_valid stalls the loader with all of
// its state held.
//
// dbg_state exposes the loader FSM state: 0 IDLE, 1 CNT_HI, 2 CNT_LO, 3 DATA,
// 4 WRITE, 5 CHK, 6 DONE, 7 ERR.
interface im_loader_if #(
    parameter int AW = 5
);
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          im_we;
    logic [AW-1:0] im_addr;
    logic [31:0]   im_wdata;
    logic          busy;
    logic          done;
    logic          err;
    logic [2:0]    dbg_state;

    // Loader side.
    modport master (
        input  in_data, in_valid,
        output in_ready, im_we, im_addr, im_wdata, busy, done, err, dbg_state
    );

    // Stream source / memory / CPU side.
    modport slave (
        output in_data, in_valid,
        input  in_ready, im_we, im_addr, im_wdata, busy, done, err, dbg_state
    );
endinterface

// File: rtl/im_loader.sv
// Instruction-memory loader.
//
// Frame format: 0xA5, count high byte, count low byte, count words of four
// bytes each (MSB first), then one checksum byte. The checksum is the XOR of
// the payload bytes only. Each word is written in a one-cycle WRITE state.
// A checksum mismatch ends in ERR. A count larger than NMEM also ends in ERR.
// Words already written are kept in both cases.
module im_loader #(
    parameter int NMEM = 20,
    parameter int AW   = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    im_loader_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CNT_HI = 3'd1,
        S_CNT_LO = 3'd2,
        S_DATA   = 3'd3,
        S_WRITE  = 3'd4,
        S_CHK    = 3'd5,
        S_DONE   = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    localparam logic [31:0] NMEM_U = 32'(NMEM);

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_run;      // low during reset and for the first cycle after it
    logic [15:0]   r_cnt;
    logic [31:0]   r_asm;
    logic [7:0]    r_chk;
    logic [AW-1:0] r_addr;
    logic [1:0]    r_bidx;     // byte position within the current word

    logic          w_in_ready;
    logic          w_acc;
    logic [15:0]   w_count;
    logic          w_last_word;
    logic          w_im_we;
    logic          w_busy;
    logic          w_done;
    logic          w_err;

    assign w_acc       = bus.in_valid && w_in_ready;
    assign w_count     = {r_cnt[15:8], bus.in_data};
    assign w_last_word = (32'(r_addr) + 32'd1) == {16'd0, r_cnt};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode. A header byte only resynchronises in IDLE, DONE and ERR.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (w_acc && bus.in_data == 8'hA5) w_state_nxt = S_CNT_HI;
            end
            S_CNT_HI: begin
                if (w_acc) w_state_nxt = S_CNT_LO;
            end
            S_CNT_LO: begin
                if (w_acc) begin
                    if (w_count == 16'd0)             w_state_nxt = S_CHK;
                    else if (32'(w_count) > NMEM_U)   w_state_nxt = S_ERR;
                    else                              w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (w_acc && r_bidx == 2'd3) w_state_nxt = S_WRITE;
            end
            S_WRITE: begin
                w_state_nxt = w_last_word ? S_CHK : S_DATA;
            end
            S_CHK: begin
                if (w_acc) w_state_nxt = (bus.in_data == r_chk) ? S_DONE : S_ERR;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode. r_run keeps in_ready low until the first edge after reset.
    always_comb begin
        w_in_ready = 1'b0;
        w_im_we    = 1'b0;
        w_busy     = 1'b0;
        w_done     = 1'b0;
        w_err      = 1'b0;
        w_in_ready = r_run && (r_state != S_WRITE);
        w_im_we    = (r_state == S_WRITE);
        w_busy     = (r_state == S_CNT_HI) || (r_state == S_CNT_LO) ||
                     (r_state == S_DATA)   || (r_state == S_WRITE)  ||
                     (r_state == S_CHK);
        w_done     = (r_state == S_DONE);
        w_err      = (r_state == S_ERR);
    end

    // Datapath: count capture, word assembly, checksum and write address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run  <= 1'b0;
            r_cnt  <= 16'd0;
            r_asm  <= 32'd0;
            r_chk  <= 8'd0;
            r_addr <= '0;
            r_bidx <= 2'd0;
        end else begin
            r_run <= 1'b1;
            case (r_state)
                S_CNT_HI: begin
                    if (w_acc) r_cnt[15:8] <= bus.in_data;
                end
                S_CNT_LO: begin
                    // Leaving CNT_LO starts a fresh payload at word 0.
                    if (w_acc) begin
                        r_cnt[7:0] <= bus.in_data;
                        r_addr     <= '0;
                        r_chk      <= 8'd0;
                        r_bidx     <= 2'd0;
                    end
                end
                S_DATA: begin
                    if (w_acc) begin
                        r_asm  <= {r_asm[23:0], bus.in_data};
                        r_chk  <= r_chk ^ bus.in_data;
                        r_bidx <= r_bidx + 2'd1;
                    end
                end
                S_WRITE: begin
                    r_addr <= r_addr + AW'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.im_we     = w_im_we;
    assign bus.im_addr   = r_addr;
    assign bus.im_wdata  = r_asm;
    assign bus.busy      = w_busy;
    assign bus.done      = w_done;
    assign bus.err       = w_err;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench for im_loader.
module tb_im_loader;
  localparam int NMEM = 20;
  localparam int AW   = 5;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  im_loader_if #(.AW(AW)) bus ();

  im_loader #(.NMEM(NMEM), .AW(AW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- reference model state ----------------
  logic [AW+31:0] exp_q[$];     // expected {addr, data} writes, in order
  logic [7:0]     frame_q[$];   // bytes of the frame to send
  logic [31:0]    words[$];     // payload words of the frame
  bit             exp_done;
  bit             exp_err;

  // ---------------- scoreboard / monitor ----------------
  int             n_writes     = 0;
  int             rdy_hi_in_wr = 0;
  int             rdy_lo_out_wr = 0;
  bit             arm_rdy      = 1'b0;
  logic [AW+31:0] sb_e;

  always @(negedge clk) begin
    if (rst_n && bus.im_we) begin
      n_writes++;
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected_write addr=%0d data=%h required no write",
                 bus.im_addr, bus.im_wdata);
      end else begin
        sb_e = exp_q.pop_front();
        if ({bus.im_addr, bus.im_wdata} !== sb_e)
          $display("FAIL sb_write got addr=%0d data=%h required addr=%0d data=%h",
                   bus.im_addr, bus.im_wdata, sb_e[AW+31:32], sb_e[31:0]);
        else
          n_pass++;
      end
    end
    if (arm_rdy && rst_n) begin
      if (bus.im_we && bus.in_ready)   rdy_hi_in_wr++;
      if (!bus.im_we && !bus.in_ready) rdy_lo_out_wr++;
    end
  end

  // Frame model: builds the byte stream and the expected writes and outcome.
  // chk_mode: -1 correct checksum, -2 corrupted checksum, >=0 explicit value.
  task automatic model_frame(input int cnt, input int chk_mode);
    logic [15:0] c16;
    logic [7:0]  x;
    logic [7:0]  b;
    logic [7:0]  chk;
    c16 = 16'(cnt);
    frame_q.delete();
    exp_q.delete();
    frame_q.push_back(8'hA5);
    frame_q.push_back(c16[15:8]);
    frame_q.push_back(c16[7:0]);
    if (cnt > NMEM) begin
      exp_done = 1'b0;
      exp_err  = 1'b1;
      return;
    end
    x = 8'h00;
    for (int i = 0; i < cnt; i++) begin
      for (int k = 3; k >= 0; k--) begin
        b = words[i][8*k +: 8];
        frame_q.push_back(b);
        x = x ^ b;
      end
      exp_q.push_back({AW'(i), words[i]});
    end
    if (chk_mode == -1)      chk = x;
    else if (chk_mode == -2) chk = x ^ 8'(($urandom_range(1, 255)));
    else                     chk = 8'(chk_mode);
    frame_q.push_back(chk);
    exp_done = (chk == x);
    exp_err  = !exp_done;
  endtask

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 after the byte was accepted.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    if (gaps) begin
      bus.in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
    end
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk);
        #1;
        break;
      end
      n++;
      if (n >= 100) begin
        n_checks++;
        $display("FAIL send_timeout byte=%h in_ready=0 for %0d cycles required 1", b, n);
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic send_frame(input bit gaps);
    while (frame_q.size() > 0) send_byte(frame_q.pop_front(), gaps);
  endtask

  task automatic nominal_words();
    words.delete();
    words.push_back(32'h11223344);
    words.push_back(32'h55667788);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    rst_n = 1'b0;
    #12;
    n_checks++;
    if ({bus.in_ready, bus.im_we, bus.busy, bus.done, bus.err, bus.im_addr, bus.im_wdata, bus.dbg_state} !== '0)
      $display("FAIL reset_outputs rdy=%b we=%b busy=%b done=%b err=%b addr=%0d wdata=%h st=%0d required all 0",
               bus.in_ready, bus.im_we, bus.busy, bus.done, bus.err, bus.im_addr, bus.im_wdata, bus.dbg_state);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b0) $display("FAIL reset_ready_early got %b required 0", bus.in_ready);
    else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) $display("FAIL reset_ready_rise got %b required 1", bus.in_ready);
    else n_pass++;
  endtask

  task automatic test_zero_junk();
    int w0;
    w0 = n_writes;
    send_byte(8'h00, 1'b0);
    send_byte(8'hFF, 1'b0);
    n_checks++;
    if ({bus.dbg_state, bus.busy, bus.done, bus.err} !== 6'd0)
      $display("FAIL junk_ignored st=%0d busy=%b done=%b err=%b required IDLE 0 0 0",
               bus.dbg_state, bus.busy, bus.done, bus.err);
    else n_pass++;
    words.delete();
    model_frame(0, 0);
    send_frame(1'b0);
    n_checks++;
    if ({bus.done, bus.err, bus.busy} !== {exp_done, exp_err, 1'b0})
      $display("FAIL zero_count_end done=%b err=%b busy=%b required %b %b 0",
               bus.done, bus.err, bus.busy, exp_done, exp_err);
    else n_pass++;
    n_checks++;
    if (n_writes !== w0) $display("FAIL zero_count_writes got %0d required 0", n_writes - w0);
    else n_pass++;
  endtask

  task automatic test_nominal();
    nominal_words();
    model_frame(2, -1);
    for (int i = 0; i < 7; i++) send_byte(frame_q.pop_front(), 1'b0);
    // The edge that took 0x44 must be followed directly by the write cycle.
    n_checks++;
    if ({bus.im_we, bus.in_ready, bus.im_addr} !== {1'b1, 1'b0, AW'(0)})
      $display("FAIL nominal_latency we=%b rdy=%b addr=%0d required 1 0 0",
               bus.im_we, bus.in_ready, bus.im_addr);
    else n_pass++;
    send_frame(1'b0);
    n_checks++;
    if ({bus.done, bus.err, bus.busy} !== {exp_done, exp_err, 1'b0} || exp_done !== 1'b1)
      $display("FAIL nominal_end done=%b err=%b busy=%b required 1 0 0", bus.done, bus.err, bus.busy);
    else n_pass++;
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL nominal_writes_missing left=%0d required 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_bad_chk();
    nominal_words();
    model_frame(2, 0);
    send_frame(1'b0);
    n_checks++;
    if ({bus.done, bus.err, bus.busy} !== 3'b010)
      $display("FAIL badchk_end done=%b err=%b busy=%b required 0 1 0", bus.done, bus.err, bus.busy);
    else n_pass++;
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL badchk_writes_missing left=%0d required 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_range();
    int w0;
    w0 = n_writes;
    words.delete();
    model_frame(NMEM + 1, -1);
    send_frame(1'b0);
    n_checks++;
    if ({bus.done, bus.err, bus.busy} !== 3'b010 || n_writes !== w0)
      $display("FAIL range_err done=%b err=%b busy=%b writes=%0d required 0 1 0 writes 0",
               bus.done, bus.err, bus.busy, n_writes - w0);
    else n_pass++;
    words.push_back(32'hA5A5C0DE);
    model_frame(1, -1);
    send_byte(frame_q.pop_front(), 1'b0);
    n_checks++;
    if ({bus.err, bus.busy} !== 2'b01)
      $display("FAIL range_err_clear err=%b busy=%b required 0 1", bus.err, bus.busy);
    else n_pass++;
    send_frame(1'b0);
    n_checks++;
    if ({bus.done, bus.err, bus.busy} !== 3'b100 || exp_q.size() != 0)
      $display("FAIL range_recover done=%b err=%b busy=%b left=%0d required 1 0 0 left 0",
               bus.done, bus.err, bus.busy, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int w0;
    w0 = n_writes;
    nominal_words();
    model_frame(2, -1);
    rdy_hi_in_wr  = 0;
    rdy_lo_out_wr = 0;
    arm_rdy = 1'b1;
    send_frame(1'b1);
    arm_rdy = 1'b0;
    n_checks++;
    if ({bus.done, bus.err, bus.busy} !== 3'b100 || exp_q.size() != 0 || n_writes - w0 != 2)
      $display("FAIL bp_end done=%b err=%b busy=%b left=%0d writes=%0d required 1 0 0 left 0 writes 2",
               bus.done, bus.err, bus.busy, exp_q.size(), n_writes - w0);
    else n_pass++;
    n_checks++;
    if (rdy_hi_in_wr != 0 || rdy_lo_out_wr != 0)
      $display("FAIL bp_ready_in_write ready_high_in_write=%0d ready_low_elsewhere=%0d required 0 0",
               rdy_hi_in_wr, rdy_lo_out_wr);
    else n_pass++;
  endtask

  task automatic test_reset_midframe();
    nominal_words();
    model_frame(2, -1);
    for (int i = 0; i < 6; i++) send_byte(frame_q.pop_front(), 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.in_ready, bus.im_we, bus.busy, bus.done, bus.err, bus.im_addr, bus.im_wdata, bus.dbg_state} !== '0)
      $display("FAIL midreset_outputs rdy=%b we=%b busy=%b done=%b err=%b addr=%0d wdata=%h st=%0d required all 0",
               bus.in_ready, bus.im_we, bus.busy, bus.done, bus.err, bus.im_addr, bus.im_wdata, bus.dbg_state);
    else n_pass++;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    nominal_words();
    model_frame(2, -1);
    send_frame(1'b0);
    n_checks++;
    if ({bus.done, bus.err, bus.busy} !== 3'b100 || exp_q.size() != 0)
      $display("FAIL midreset_reload done=%b err=%b busy=%b left=%0d required 1 0 0 left 0",
               bus.done, bus.err, bus.busy, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_random();
    int cnt;
    int mode;
    for (int f = 0; f < 8; f++) begin
      cnt  = (f == 0) ? NMEM : $urandom_range(1, 4);
      mode = ($urandom_range(0, 2) == 0) ? -2 : -1;
      words.delete();
      for (int i = 0; i < cnt; i++) begin
        logic [31:0] w;
        for (int k = 0; k < 4; k++)
          w[8*k +: 8] = ($urandom_range(0, 5) == 0) ? 8'hA5 : 8'($urandom);
        words.push_back(w);
      end
      model_frame(cnt, mode);
      send_frame(1'($urandom_range(0, 1)));
      n_checks++;
      if ({bus.done, bus.err, bus.busy} !== {exp_done, exp_err, 1'b0} || exp_q.size() != 0)
        $display("FAIL random_frame%0d cnt=%0d done=%b err=%b busy=%b left=%0d required %b %b 0 left 0",
                 f, cnt, bus.done, bus.err, bus.busy, exp_q.size(), exp_done, exp_err);
      else n_pass++;
    end
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    test_reset();
    test_zero_junk();
    test_nominal();
    test_bad_chk();
    test_range();
    test_backpressure();
    test_reset_midframe();
    test_random();
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end
endmodule
